// File: rtl/moving_avg_pkg.sv
// Shared types and sizing for the moving-average controller.
// The accumulator is ADDR_WIDTH bits wider than a sample so that the sum of
// a full window of extreme values always fits.
package moving_avg_pkg;

    // Controller phases: CLEAR zeroes the window, RUN accepts samples.
    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    localparam int DEF_DATA_WIDTH = 24;
    localparam int DEF_ADDR_WIDTH = 4;

    // Accumulator width for the default configuration.
    localparam int ACC_WIDTH = DEF_DATA_WIDTH + DEF_ADDR_WIDTH;

    // Accumulator width for an arbitrary configuration.
    function automatic int acc_width(input int data_width, input int addr_width);
        return data_width + addr_width;
    endfunction

endpackage

// File: rtl/reg_file.sv
// Simple register file: one synchronous write port, one asynchronous read
// port. Contents are not reset; the owner is responsible for initialising them.
module reg_file #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  w_en,
    input  logic [ADDR_WIDTH-1:0] w_addr,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic [ADDR_WIDTH-1:0] r_addr,
    output logic [DATA_WIDTH-1:0] r_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    // Write port: store w_data at w_addr when enabled.
    always_ff @(posedge clk) begin
        if (w_en) begin
            mem_r[w_addr] <= w_data;
        end
    end

    assign r_data = mem_r[r_addr];

endmodule

// File: rtl/moving_avg_ctrl.sv
// Moving-average controller over a window of N = 2**ADDR_WIDTH signed samples.
// A running sum is kept: each accepted sample replaces the oldest entry and
// the sum is adjusted by (new - old). The average is the sum shifted right
// arithmetically by ADDR_WIDTH, i.e. floor division by N. Until the window
// has been filled the missing entries read as zero.
module moving_avg_ctrl
    import moving_avg_pkg::*;
#(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic                         primed
);

    localparam int SUM_W = acc_width(DATA_WIDTH, ADDR_WIDTH);
    localparam int N     = 1 << ADDR_WIDTH;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH:0]   FILL_FULL = (ADDR_WIDTH + 1)'(N);
    localparam logic [ADDR_WIDTH:0]   FILL_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0]   FILL_ZERO = (ADDR_WIDTH + 1)'(0);
    localparam logic signed [SUM_W-1:0]      SUM_ZERO  = SUM_W'(0);
    localparam logic signed [DATA_WIDTH-1:0] DATA_ZERO = DATA_WIDTH'(0);

    // Control state
    state_e                  state_r;
    state_e                  state_s;
    logic [ADDR_WIDTH-1:0]   clr_cnt_r;
    logic [ADDR_WIDTH-1:0]   wptr_r;
    logic [ADDR_WIDTH:0]     fill_r;

    // Datapath state
    logic signed [SUM_W-1:0]      sum_r;
    logic signed [SUM_W-1:0]      sum_next_s;
    logic signed [SUM_W-1:0]      in_ext_s;
    logic signed [SUM_W-1:0]      old_ext_s;
    logic                         out_valid_r;
    logic signed [DATA_WIDTH-1:0] out_data_r;

    // Decoded controls and storage port signals
    logic                    in_ready_s;
    logic                    accept_s;
    logic                    w_en_s;
    logic [ADDR_WIDTH-1:0]   w_addr_s;
    logic [DATA_WIDTH-1:0]   w_data_s;
    logic [DATA_WIDTH-1:0]   old_s;

    reg_file #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_reg_file (
        .clk    (clk),
        .w_en   (w_en_s),
        .w_addr (w_addr_s),
        .w_data (w_data_s),
        .r_addr (wptr_r),
        .r_data (old_s)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= CLEAR;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state: CLEAR lasts until the last address has been zeroed, a flush
    // in either state (re)starts the clear sweep.
    always_comb begin
        state_s = state_r;
        case (state_r)
            CLEAR: begin
                if (!flush && (clr_cnt_r == LAST_ADDR)) begin
                    state_s = RUN;
                end else begin
                    state_s = CLEAR;
                end
            end
            RUN: begin
                if (flush) begin
                    state_s = CLEAR;
                end else begin
                    state_s = RUN;
                end
            end
            default: begin
                state_s = CLEAR;
            end
        endcase
    end

    // Outputs of the FSM: handshake, accept strobe and storage write port.
    always_comb begin
        in_ready_s = 1'b0;
        accept_s   = 1'b0;
        w_en_s     = 1'b0;
        w_addr_s   = wptr_r;
        w_data_s   = in_data;
        case (state_r)
            CLEAR: begin
                w_en_s   = 1'b1;
                w_addr_s = clr_cnt_r;
                w_data_s = DATA_ZERO;
            end
            RUN: begin
                // A held result blocks input until downstream takes it.
                in_ready_s = !out_valid_r || out_ready;
                // A same-cycle flush discards the sample.
                accept_s   = in_ready_s && in_valid && !flush;
                w_en_s     = accept_s;
                w_addr_s   = wptr_r;
                w_data_s   = in_data;
            end
            default: begin
                in_ready_s = 1'b0;
                accept_s   = 1'b0;
                w_en_s     = 1'b0;
            end
        endcase
    end

    // Running-sum update: add the new sample, drop the one it replaces.
    always_comb begin
        in_ext_s   = {{ADDR_WIDTH{in_data[DATA_WIDTH-1]}}, in_data};
        old_ext_s  = {{ADDR_WIDTH{old_s[DATA_WIDTH-1]}}, old_s};
        sum_next_s = sum_r + in_ext_s - old_ext_s;
    end

    // Clear sweep address: advances only while clearing, restarts on flush.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clr_cnt_r <= ADDR_ZERO;
        end else if ((state_r == CLEAR) && !flush) begin
            clr_cnt_r <= clr_cnt_r + ADDR_ONE;
        end else begin
            clr_cnt_r <= ADDR_ZERO;
        end
    end

    // Window write pointer, running sum and fill counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_r <= ADDR_ZERO;
            sum_r  <= SUM_ZERO;
            fill_r <= FILL_ZERO;
        end else if ((state_r == CLEAR) || flush) begin
            wptr_r <= ADDR_ZERO;
            sum_r  <= SUM_ZERO;
            fill_r <= FILL_ZERO;
        end else if (accept_s) begin
            wptr_r <= wptr_r + ADDR_ONE;
            sum_r  <= sum_next_s;
            if (fill_r != FILL_FULL) begin
                fill_r <= fill_r + FILL_ONE;
            end else begin
                fill_r <= fill_r;
            end
        end else begin
            wptr_r <= wptr_r;
            sum_r  <= sum_r;
            fill_r <= fill_r;
        end
    end

    // Result register: load on accept, hold while stalled, drop when taken.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= DATA_ZERO;
        end else if ((state_r == CLEAR) || flush) begin
            out_valid_r <= 1'b0;
            out_data_r  <= out_data_r;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            // Upper DATA_WIDTH bits of the sum == sum >>> ADDR_WIDTH.
            out_data_r  <= sum_next_s[SUM_W-1:ADDR_WIDTH];
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
            out_data_r  <= out_data_r;
        end else begin
            out_valid_r <= out_valid_r;
            out_data_r  <= out_data_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign primed    = (fill_r == FILL_FULL);

endmodule

// File: tb/tb_moving_avg_ctrl.sv
// Self-checking bench for moving_avg_ctrl (DATA_WIDTH=24, ADDR_WIDTH=4).
// A table of single-sample vectors with expected averages drives the main
// sequence; a reference model fed at every accept pushes expected results
// into a queue that is popped when the DUT presents each new result.
module tb_moving_avg_ctrl;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic signed [23:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic signed [23:0] out_data;
    logic               primed;

    int tests = 0;
    int fails = 0;

    moving_avg_ctrl #(
        .DATA_WIDTH (24),
        .ADDR_WIDTH (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .primed    (primed)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    int     win [16];
    int     widx;
    longint msum;
    int     exp_q [$];
    bit     pend = 1'b0;

    function automatic longint floor16(input longint s);
        if (s >= 0) return s / 16;
        else        return -((-s + 15) / 16);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) win[i] = 0;
        widx = 0;
        msum = 0;
        exp_q.delete();
    endtask

    // Sample mid-cycle: check the result of the previous accept, then log
    // whether an accept happens at the coming rising edge.
    always @(negedge clk) begin
        if (!reset_n) begin
            model_clear();
            pend = 1'b0;
        end else begin
            if (pend) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    check("sb_valid", out_valid, 1);
                    check("sb_data", out_data, e);
                end
            end
            pend = 1'b0;
            if (flush) begin
                model_clear();
            end else if (in_valid && in_ready) begin
                int d;
                d = in_data;
                msum = msum + d - win[widx];
                win[widx] = d;
                widx = (widx + 1) % 16;
                exp_q.push_back(int'(floor16(msum)));
                pend = 1'b1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Offer one sample, wait (bounded) for it to be taken, optionally check
    // the result presented one cycle later.
    task automatic send(input logic signed [23:0] d, input string name,
                        input logic signed [23:0] exp_avg, input bit exp_pr,
                        input bit do_chk);
        int waited = 0;
        in_valid = 1'b1;
        in_data  = d;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 100) break;
        end
        if (waited > 100) begin
            check({name, "_timeout"}, 0, 1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #2;
            in_valid = 1'b0;
            if (do_chk) begin
                check({name, "_valid"}, out_valid, 1);
                check({name, "_data"}, out_data, exp_avg);
                check({name, "_primed"}, primed, exp_pr);
            end
        end
    endtask

    // Count cycles with in_ready low until it rises; outputs must stay quiet.
    task automatic count_clear(input string name);
        int n = 0;
        bit bad = 1'b0;
        while (n < 100) begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (out_valid || primed) bad = 1'b1;
        end
        check({name, "_len"}, n, 16);
        check({name, "_quiet"}, bad, 0);
        @(posedge clk);
        #2;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk);
        #2;
        flush = 1'b0;
    endtask

    // Backpressure: stall 5 cycles with a sample waiting, then resume.
    task automatic stall_test();
        logic signed [23:0] held;
        int v = 5;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 24'(v);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("burst_ready", in_ready, 1);
            @(posedge clk);
            #2;
            v += 5;
            in_data = 24'(v);
        end
        out_ready = 1'b0;
        held = out_data;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_ready", in_ready, 0);
            check("stall_valid", out_valid, 1);
            check("stall_data", out_data, held);
        end
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("resume_ready", in_ready, 1);
            @(posedge clk);
            #2;
            v += 5;
            in_data = 24'(v);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #2;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic signed [23:0] din;
        logic signed [23:0] exp_avg;
        bit                 exp_primed;
    } vec_t;

    vec_t vecs [32];

    initial begin
        // Fill with 160s (average climbs by 10), then drain with zeros.
        for (int i = 0; i < 16; i++) begin
            vecs[i].din        = 24'sd160;
            vecs[i].exp_avg    = 24'(10 * (i + 1));
            vecs[i].exp_primed = (i == 15);
        end
        for (int i = 0; i < 16; i++) begin
            vecs[16 + i].din        = 24'sd0;
            vecs[16 + i].exp_avg    = 24'(150 - 10 * i);
            vecs[16 + i].exp_primed = 1'b1;
        end

        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 24'sd0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_primed", primed, 0);
        reset_n = 1'b1;
        count_clear("rst_clear");

        for (int i = 0; i < 32; i++) begin
            send(vecs[i].din, $sformatf("vec%0d", i), vecs[i].exp_avg,
                 vecs[i].exp_primed, 1'b1);
        end

        // Floor rounding and full-scale extremes.
        do_flush();
        count_clear("clr_a");
        send(-24'sd1, "neg_one", -24'sd1, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) send(24'sh7FFFFF, "max", 24'sd0, 1'b0, 1'b0);
        check("max_data", out_data, 24'sh7FFFFF);
        check("max_primed", primed, 1);
        for (int i = 0; i < 16; i++) send(24'sh800000, "min", 24'sd0, 1'b0, 1'b0);
        check("min_data", out_data, 24'sh800000);

        stall_test();

        // Flush mid-fill: dilution restarts from an empty window.
        do_flush();
        count_clear("clr_b");
        for (int i = 0; i < 7; i++) send(24'sd100, "pre7", 24'sd0, 1'b0, 1'b0);
        do_flush();
        count_clear("flush7_clear");
        send(24'sd32, "after_flush", 24'sd2, 1'b0, 1'b1);

        // Reset in the middle of a clear sweep restarts the full sweep.
        do_flush();
        repeat (5) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_in_ready", in_ready, 0);
        check("midrst_out_valid", out_valid, 0);
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
        count_clear("midrst_clear");
        send(24'sd48, "after_rst", 24'sd3, 1'b0, 1'b1);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard stop if the sequence ever gets stuck.
    initial begin
        #500000;
        fails++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog expired");
    end

endmodule
